// File: rtl/word_8bit.sv
// word_8bit: single storage word of the SRAM-style array.
// Writes on the rising clk edge when the word is selected for write (sel & rw).
// The stored contents are always driven on data_out. rst_n clears the word
// asynchronously to RESET_VALUE.
// Optional build macro WORD8BIT_PARITY_EN adds a stored even-parity bit and
// a parity_err output.
module word_8bit #(
    parameter int unsigned         WIDTH       = 8,
    parameter logic [WIDTH-1:0]    RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             sel,
    input  logic             rw,
`ifdef WORD8BIT_PARITY_EN
    output logic [WIDTH-1:0] data_out,
    output logic             parity_err
`else
    output logic [WIDTH-1:0] data_out
`endif
);

    // Write enable is decided only by the control inputs, never by data.
    logic we;
    assign we = sel & rw;

    // Word storage; data_out is the storage register, so a write is visible
    // right after the sampling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= RESET_VALUE;
        end else if (we) begin
            data_out <= data_in;
        end
    end

`ifdef WORD8BIT_PARITY_EN
    // Stored even-parity bit, written together with the word.
    logic parity_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_bit <= ^RESET_VALUE;
        end else if (we) begin
            parity_bit <= ^data_in;
        end
    end

    // Any mismatch between stored word and stored parity flags an error.
    assign parity_err = (^data_out) ^ parity_bit;
`endif

endmodule

// File: tb/tb_word_8bit.sv
// Self-checking bench for word_8bit: directed vector table, hand-written
// asynchronous-reset and between-edge sequences, then randomized traffic
// compared against a simple memory-word model.
module tb_word_8bit;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_in;
    logic       sel;
    logic       rw;
    logic [7:0] data_out;
`ifdef WORD8BIT_PARITY_EN
    logic       parity_err;
`endif

    int checks = 0;
    int errors = 0;

    word_8bit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .sel        (sel),
        .rw         (rw),
`ifdef WORD8BIT_PARITY_EN
        .data_out   (data_out),
        .parity_err (parity_err)
`else
        .data_out   (data_out)
`endif
    );

    // 10 ns clock: negedges at multiples of 10, posedges at 5 + 10k.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       sel;
        logic       rw;
        logic [7:0] din;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Drive one cycle's controls at the negedge, sample 1 ns after the posedge.
    task automatic cycle(input logic s, input logic r, input logic [7:0] d);
        @(negedge clk);
        sel     = s;
        rw      = r;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] model;
        logic       s, r, pulse;
        logic [7:0] d;

        vecs[0]  = '{1'b1, 1'b1, 8'h55, 8'h55, "write 01010101"};
        vecs[1]  = '{1'b1, 1'b0, 8'hxx, 8'h55, "read x data"};
        vecs[2]  = '{1'b1, 1'b1, 8'hA0, 8'hA0, "write 10100000"};
        vecs[3]  = '{1'b1, 1'b0, 8'h00, 8'hA0, "read 10100000"};
        vecs[4]  = '{1'b0, 1'b1, 8'hFF, 8'hA0, "hold 1"};
        vecs[5]  = '{1'b0, 1'b1, 8'hFF, 8'hA0, "hold 2"};
        vecs[6]  = '{1'b1, 1'b0, 8'hFF, 8'hA0, "read after hold"};
        vecs[7]  = '{1'b0, 1'b0, 8'h33, 8'hA0, "idle"};
        vecs[8]  = '{1'b1, 1'b1, 8'hFF, 8'hFF, "write all ones"};
        vecs[9]  = '{1'b1, 1'b1, 8'hFF, 8'hFF, "rewrite same"};
        vecs[10] = '{1'b1, 1'b1, 8'h00, 8'h00, "write zero"};
        vecs[11] = '{1'b1, 1'b1, 8'h80, 8'h80, "bit7 only"};
        vecs[12] = '{1'b1, 1'b1, 8'h01, 8'h01, "bit0 only"};

        // Reset held with a pending write; reset must win across a clock edge.
        rst_n   = 1'b0;
        sel     = 1'b1;
        rw      = 1'b1;
        data_in = 8'hFF;
        #1;
        check("reset early", data_out, 8'h00);
        @(posedge clk);
        #1;
        check("reset across edge", data_out, 8'h00);
        @(negedge clk);
        rw    = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("read after reset", data_out, 8'h00);

        foreach (vecs[i]) begin
            cycle(vecs[i].sel, vecs[i].rw, vecs[i].din);
            check(vecs[i].name, data_out, vecs[i].exp);
        end

        // Asynchronous reset between edges takes effect immediately.
        cycle(1'b1, 1'b1, 8'hA0);
        check("pre reset word", data_out, 8'hA0);
        @(negedge clk);
        sel = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset immediate", data_out, 8'h00);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, 1'b0, 8'h5A);
        check("read after mid reset", data_out, 8'h00);
        cycle(1'b1, 1'b1, 8'hCC);
        check("write after mid reset", data_out, 8'hCC);

        // Only control values present at the rising edge matter.
        @(negedge clk);
        sel = 1'b1; rw = 1'b1; data_in = 8'h11;
        #2;
        sel = 1'b0;
        @(posedge clk);
        #1;
        check("sel dropped before edge", data_out, 8'hCC);
        @(negedge clk);
        sel = 1'b0; rw = 1'b0; data_in = 8'h22;
        #2;
        sel = 1'b1; rw = 1'b1;
        @(posedge clk);
        #1;
        check("sel raised before edge", data_out, 8'h22);
        sel = 1'b0;
        #2;
        check("sel change after edge", data_out, 8'h22);

`ifdef WORD8BIT_PARITY_EN
        cycle(1'b1, 1'b1, 8'hB0);
        check("parity clean write", {7'd0, parity_err}, 8'h00);
        force dut.parity_bit = 1'b0;
        #1;
        check("parity corrupted", {7'd0, parity_err}, 8'h01);
        release dut.parity_bit;
        @(negedge clk);
        sel   = 1'b0;
        rst_n = 1'b0;
        #1;
        check("parity after reset", {7'd0, parity_err}, 8'h00);
        rst_n = 1'b1;
`endif

        // Randomized traffic against a one-word memory model.
        model = data_out;
        for (int n = 0; n < 400; n++) begin
            s     = 1'($urandom_range(0, 1));
            r     = 1'($urandom_range(0, 1));
            d     = 8'($urandom);
            pulse = ($urandom_range(0, 19) == 0);
            @(negedge clk);
            sel     = s;
            rw      = r;
            data_in = d;
            if (pulse) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
                model = 8'h00;
            end
            @(posedge clk);
            #1;
            if (s && r) model = d;
            check("random word", data_out, model);
`ifdef WORD8BIT_PARITY_EN
            check("random parity", {7'd0, parity_err}, 8'h00);
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/word_8bit.md
Name: word_8bit

Overview:
- Single 8-bit storage word: eight bit cells sharing one select and one read/write control.
- Basic addressable unit of the SRAM-style memory array; an address decoder drives `sel`, and `data_out` feeds the array read path.
- Writes are synchronous to `clk`. Contents are always visible on `data_out`. Asynchronous active-low reset clears the word.

Parameters:
- WIDTH, 8, number of bit cells in the word. Only 8 is required to be supported; all widths below follow WIDTH.
- RESET_VALUE, 8'h00, value loaded into the word on reset.

Ports:
- clk  input  1  system clock; all writes occur on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low; clears the word to RESET_VALUE.
- data_in  input  8  write data; ignored unless a write is enabled.
- sel  input  1  word select; 1 = word addressed, 0 = word holds.
- rw  input  1  read/write control; 1 = write, 0 = read.
- data_out  output  8  stored word contents.

Behaviour:
- Reset:
  - rst_n low immediately forces storage and data_out to RESET_VALUE (00000000), independent of clk.
  - Release is synchronous in effect: the first possible write is at the first rising edge with rst_n high.
- Write enable: we = sel & rw.
- On rising clk with we = 1: storage <= data_in, all 8 bits simultaneously.
- Write latency: data_out shows the new value immediately after the sampling edge (same edge, no extra cycle).
- Read (sel = 1, rw = 0): storage unchanged; data_out = storage. data_in is a don't-care, including X/Z values; it must not disturb storage.
- Hold (sel = 0): storage unchanged regardless of rw and data_in; data_out still = storage.
- data_out is driven continuously from storage; it is never tri-stated and never X after reset.
- Bit structure: each bit is an independent cell with in, we, and out. Bit i of data_in maps to bit i of data_out; there is no bit reordering.
- Boundary conditions:
  - Reset asserted while sel = 1 and rw = 1: reset wins, storage = 00000000.
  - Reset asserted mid-sequence: the next read returns 00000000 until a new write.
  - Writing the same value repeatedly leaves data_out stable, with no glitch.
  - sel or rw changing between edges has no effect; only values at the rising edge matter.
- The write-enable decision must not depend on data_in.

Optional Feature:
- Macro WORD8BIT_PARITY_EN.
- When defined:
  - A ninth storage bit holds even parity of data_in, written with the word.
  - Extra output `parity_err` (1 bit) = XOR of the stored 8 bits and the stored parity bit.
  - Reset clears the parity bit, so parity_err = 0 after reset.
  - parity_err is 0 for any value written through the normal write path.
- When not defined: no parity bit, no parity_err port. Behaviour is otherwise identical.

Test Plan:
- Reset: rst_n = 0 for 10 ns with sel = 1, rw = 1, data_in = 11111111 -> data_out = 00000000 throughout; release, then read -> 00000000.
- Write/read 1: sel = 1, rw = 1, data_in = 01010101, one clk edge -> data_out = 01010101. Then rw = 0, data_in = xxxxxxxx -> data_out stays 01010101.
- Write/read 2: sel = 1, rw = 1, data_in = 10100000, one edge -> data_out = 10100000. Then rw = 0 for one cycle -> 10100000.
- Hold: sel = 0, rw = 1, data_in = 11111111 for two edges -> data_out remains 10100000. Then sel = 1, rw = 0 -> 10100000.
- Async reset mid-operation: word = 10100000, assert rst_n low between clock edges -> data_out = 00000000 immediately. Write 11001100 after release -> 11001100.
- Parity (WORD8BIT_PARITY_EN defined): write 10110000 -> parity_err = 0. Force the stored parity bit to the wrong value in the bench -> parity_err = 1. Reset -> parity_err = 0.
